// File: rtl/esp8266_ipd_parser.sv
// Extracts 4-byte ASCII commands from ESP8266 "+IPD,<len>:" frames and applies them.
// Define IPD_LINKID_EN for the multi-connection header "+IPD,<id>,<len>:".
module esp8266_ipd_parser #(
   parameter int unsigned MAX_LEN     = 8,
   parameter int unsigned TIMEOUT_CYC = 50_000_000,
   parameter int unsigned THR_T_DEF   = 35,
   parameter int unsigned THR_H_DEF   = 80,
   parameter int unsigned THR_S_DEF   = 500
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_int,
   input  logic [7:0] rx_data,
   output logic       speaker_io,
   output logic [9:0] thr_temp,
   output logic [9:0] thr_hum,
   output logic [9:0] thr_soil,
   output logic       cmd_valid,
   output logic [7:0] cmd_code,
   output logic       frame_err
);

   typedef enum logic [2:0] {StHunt, StLid, StLen, StPay, StExec} state_e;

   // Timeout fires on the cycle the gap counter steps onto TIMEOUT_CYC-1.
   localparam logic [31:0] GapLast = 32'(TIMEOUT_CYC - 2);

   state_e      state_q, state_d;
   logic [2:0]  midx_q, midx_d;
   logic [7:0]  len_q, len_d;
   logic [1:0]  ndig_q, ndig_d;
   logic [7:0]  remain_q, remain_d;
   logic [7:0]  code_q, code_d;
   logic [9:0]  val_q, val_d;
   logic [2:0]  pidx_q, pidx_d;
   logic        digok_q, digok_d;
   logic [31:0] gap_q, gap_d;
   logic        speaker_q, speaker_d;
   logic [9:0]  thr_t_q, thr_t_d, thr_h_q, thr_h_d, thr_s_q, thr_s_d;
   logic        cmd_valid_q, cmd_valid_d;
   logic [7:0]  cmd_code_q, cmd_code_d;
   logic        frame_err_q, frame_err_d;
`ifdef IPD_LINKID_EN
   logic        lid_q, lid_d;
`endif

   logic is_digit, hunt_hit, err, cmd_ok, in_frame;

   function automatic logic [7:0] hdr_char(input logic [2:0] i);
      case (i)
         3'd0:    hdr_char = 8'h2B;
         3'd1:    hdr_char = 8'h49;
         3'd2:    hdr_char = 8'h50;
         3'd3:    hdr_char = 8'h44;
         default: hdr_char = 8'h2C;
      endcase
   endfunction

   assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
   assign hunt_hit = (rx_data == hdr_char(midx_q));
   assign in_frame = (state_q == StLid) || (state_q == StLen) || (state_q == StPay);

   always_comb begin
      state_d     = state_q;
      midx_d      = midx_q;
      len_d       = len_q;
      ndig_d      = ndig_q;
      remain_d    = remain_q;
      code_d      = code_q;
      val_d       = val_q;
      pidx_d      = pidx_q;
      digok_d     = digok_q;
      speaker_d   = speaker_q;
      thr_t_d     = thr_t_q;
      thr_h_d     = thr_h_q;
      thr_s_d     = thr_s_q;
      cmd_code_d  = cmd_code_q;
      cmd_valid_d = 1'b0;
      frame_err_d = 1'b0;
      err         = 1'b0;
      cmd_ok      = 1'b0;
`ifdef IPD_LINKID_EN
      lid_d       = lid_q;
`endif
      gap_d = in_frame ? (rx_int ? '0 : gap_q + 32'd1) : '0;

      case (state_q)
         StLid: if (rx_int) begin
`ifdef IPD_LINKID_EN
            if (!lid_q && rx_data >= 8'h30 && rx_data <= 8'h34) lid_d = 1'b1;
            else if (lid_q && rx_data == 8'h2C) state_d = StLen;
            else err = 1'b1;
`else
            err = 1'b1;
`endif
         end
         StLen: if (rx_int) begin
            if (is_digit) begin
               if (ndig_q == 2'd3) begin
                  err = 1'b1;
               end else begin
                  len_d  = 8'(len_q * 8'd10) + {4'b0, rx_data[3:0]};
                  ndig_d = ndig_q + 2'd1;
               end
            end else if (rx_data == 8'h3A && ndig_q != 2'd0 && len_q != 8'd0 &&
                         32'(len_q) <= MAX_LEN) begin
               state_d  = StPay;
               remain_d = len_q;
               pidx_d   = '0;
               val_d    = '0;
               digok_d  = 1'b1;
            end else begin
               err = 1'b1;
            end
         end
         StPay: if (rx_int) begin
            remain_d = remain_q - 8'd1;
            if (pidx_q == 3'd0) begin
               code_d = rx_data;
            end else if (pidx_q <= 3'd3) begin
               if (is_digit) val_d = 10'(val_q * 10'd10) + {6'b0, rx_data[3:0]};
               else digok_d = 1'b0;
            end
            if (pidx_q != 3'd4) pidx_d = pidx_q + 3'd1;
            if (remain_q == 8'd1) state_d = StExec;
         end
         StExec: begin
            state_d = StHunt;
            if (len_q == 8'd4 && digok_q) begin
               case (code_q)
                  8'h42: begin speaker_d = (val_q != '0); cmd_ok = 1'b1; end
                  8'h54: begin thr_t_d = val_q; cmd_ok = 1'b1; end
                  8'h48: begin thr_h_d = val_q; cmd_ok = 1'b1; end
                  8'h53: begin thr_s_d = val_q; cmd_ok = 1'b1; end
                  default: ;
               endcase
            end
            if (cmd_ok) begin
               cmd_valid_d = 1'b1;
               cmd_code_d  = code_q;
            end else begin
               frame_err_d = 1'b1;
            end
         end
         default: ;
      endcase

      // A strobe landing on the EXEC cycle is matched here, exactly as HUNT would.
      if ((state_q == StHunt || state_q == StExec) && rx_int) begin
         if (hunt_hit) begin
            if (midx_q == 3'd4) begin
               midx_d = '0;
               len_d  = '0;
               ndig_d = '0;
`ifdef IPD_LINKID_EN
               state_d = StLid;
               lid_d   = 1'b0;
`else
               state_d = StLen;
`endif
            end else begin
               midx_d = midx_q + 3'd1;
            end
         end else begin
            midx_d = (rx_data == 8'h2B) ? 3'd1 : 3'd0;
         end
      end

      if (in_frame && !rx_int && gap_q == GapLast) err = 1'b1;

      if (err) begin
         state_d     = StHunt;
         midx_d      = '0;
         frame_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StHunt;
         midx_q      <= '0;
         len_q       <= '0;
         ndig_q      <= '0;
         remain_q    <= '0;
         code_q      <= '0;
         val_q       <= '0;
         pidx_q      <= '0;
         digok_q     <= 1'b0;
         gap_q       <= '0;
         speaker_q   <= 1'b0;
         thr_t_q     <= 10'(THR_T_DEF);
         thr_h_q     <= 10'(THR_H_DEF);
         thr_s_q     <= 10'(THR_S_DEF);
         cmd_valid_q <= 1'b0;
         cmd_code_q  <= 8'h00;
         frame_err_q <= 1'b0;
`ifdef IPD_LINKID_EN
         lid_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         midx_q      <= midx_d;
         len_q       <= len_d;
         ndig_q      <= ndig_d;
         remain_q    <= remain_d;
         code_q      <= code_d;
         val_q       <= val_d;
         pidx_q      <= pidx_d;
         digok_q     <= digok_d;
         gap_q       <= gap_d;
         speaker_q   <= speaker_d;
         thr_t_q     <= thr_t_d;
         thr_h_q     <= thr_h_d;
         thr_s_q     <= thr_s_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_code_q  <= cmd_code_d;
         frame_err_q <= frame_err_d;
`ifdef IPD_LINKID_EN
         lid_q       <= lid_d;
`endif
      end
   end

   assign speaker_io = speaker_q;
   assign thr_temp   = thr_t_q;
   assign thr_hum    = thr_h_q;
   assign thr_soil   = thr_s_q;
   assign cmd_valid  = cmd_valid_q;
   assign cmd_code   = cmd_code_q;
   assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_esp8266_ipd_parser.sv
// Directed bench for esp8266_ipd_parser, built with a 100-cycle frame timeout.
module tb_esp8266_ipd_parser;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_int;
   logic [7:0] rx_data;
   logic       speaker_io;
   logic [9:0] thr_temp, thr_hum, thr_soil;
   logic       cmd_valid;
   logic [7:0] cmd_code;
   logic       frame_err;

   int total = 0;
   int bad   = 0;
   int n_valid = 0;
   int n_err   = 0;
   int v0, e0;

   esp8266_ipd_parser #(
      .MAX_LEN    (8),
      .TIMEOUT_CYC(100),
      .THR_T_DEF  (35),
      .THR_H_DEF  (80),
      .THR_S_DEF  (500)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_int    (rx_int),
      .rx_data   (rx_data),
      .speaker_io(speaker_io),
      .thr_temp  (thr_temp),
      .thr_hum   (thr_hum),
      .thr_soil  (thr_soil),
      .cmd_valid (cmd_valid),
      .cmd_code  (cmd_code),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   // Pulse counters sample on the active edge, so each pulse is seen exactly once.
   always @(posedge clk) begin
      if (cmd_valid === 1'b1) n_valid++;
      if (frame_err === 1'b1) n_err++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; returns at the falling edge after the strobe plus gap cycles.
   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_int  = 1'b1;
      rx_data = b;
      @(negedge clk);
      rx_int  = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_str(input string s, input int gap);
      for (int i = 0; i < s.len(); i++) send_byte(s[i], gap);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst     = 1'b1;
      rx_int  = 1'b0;
      rx_data = 8'h00;
      idle(3);
      check("rst_speaker", speaker_io, 0);
      check("rst_valid", cmd_valid, 0);
      check("rst_err", frame_err, 0);
      check("rst_code", cmd_code, 8'h00);
      check("rst_thr_t", thr_temp, 35);
      check("rst_thr_h", thr_hum, 80);
      check("rst_thr_s", thr_soil, 500);
      rst = 1'b0;
      idle(2);

      // Buzzer on, spaced strobes; outputs change two cycles after the last byte.
      send_str("+IPD,4:B00", 9);
      send_byte("1", 0);
      check("b1_spk_early", speaker_io, 0);
      idle(1);
      check("b1_spk", speaker_io, 1);
      check("b1_valid", cmd_valid, 1);
      check("b1_code", cmd_code, 8'h42);
      idle(3);
      check("b1_nvalid", n_valid, 1);
      send_str("+IPD,4:B000", 9);
      idle(3);
      check("b0_spk", speaker_io, 0);
      check("b0_nvalid", n_valid, 2);

      // Noise and doubled '+' before the header, back-to-back strobes.
      send_str("OK", 0);
      send_byte(8'h0D, 0);
      send_byte(8'h0A, 0);
      send_str("++IPD,4:T04", 0);
      send_byte("2", 0);
      check("t42_early", thr_temp, 35);
      idle(1);
      check("t42_thr_t", thr_temp, 42);
      check("t42_valid", cmd_valid, 1);
      check("t42_code", cmd_code, 8'h54);
      check("t42_thr_h", thr_hum, 80);
      check("t42_thr_s", thr_soil, 500);
      idle(3);

      // Four rejected frames, the first three followed immediately by the next.
      v0 = n_valid;
      e0 = n_err;
      send_str("+IPD,4:X123", 0);
      send_str("+IPD,4:S1a3", 0);
      send_str("+IPD,9", 0);
      send_byte(":", 0);
      check("len9_err", frame_err, 1);
      send_str("S123", 0);
      send_str("+IPD,5:S1234", 0);
      idle(4);
      check("bad_nerr", n_err - e0, 4);
      check("bad_nvalid", n_valid - v0, 0);
      check("bad_thr_s", thr_soil, 500);

      // Zero length is rejected at the colon.
      send_str("+IPD,0", 0);
      send_byte(":", 0);
      check("len0_err", frame_err, 1);
      idle(2);

      // Timeout: 100 cycles after the last strobe.
      send_str("+IPD,4:H", 0);
      send_byte("0", 0);
      idle(98);
      check("to_early", frame_err, 0);
      idle(1);
      check("to_fire", frame_err, 1);
      idle(2);
      send_str("+IPD,4:H065", 0);
      idle(3);
      check("h65_thr_h", thr_hum, 65);

      // Reset mid-frame restores defaults; the tail of the frame is ignored.
      send_str("+IPD,4:T0", 0);
      rst = 1'b1;
      #1;
      check("midrst_thr_t", thr_temp, 35);
      check("midrst_thr_h", thr_hum, 80);
      @(negedge clk);
      rst = 1'b0;
      idle(1);
      v0 = n_valid;
      send_str("99", 0);
      idle(4);
      check("midrst_nvalid", n_valid - v0, 0);
      check("midrst_thr_t2", thr_temp, 35);
      send_str("+IPD,4:T099", 0);
      idle(3);
      check("t99_thr_t", thr_temp, 99);

`ifdef IPD_LINKID_EN
      send_str("+IPD,2,4:B007", 0);
      idle(3);
      check("lid_spk_on", speaker_io, 1);
      send_str("+IPD,", 0);
      send_byte("7", 0);
      check("lid_bad_err", frame_err, 1);
      send_str(",4:B000", 0);
      idle(3);
      check("lid_spk_hold", speaker_io, 1);
`else
      send_str("+IPD,0", 0);
      send_byte(",", 0);
      check("mux_err", frame_err, 1);
      send_str("4:B007", 0);
      idle(3);
      check("mux_spk", speaker_io, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
